// File: rtl/im_arb_pkg.sv
// Shared types and helpers for the item-memory address arbiter.
package im_arb_pkg;

  // Widest requester ID the arbiter state can hold.
  localparam int unsigned MaxIdWidth = 8;

  // Width of a binary requester ID; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned num_req);
    return ($clog2(num_req) > 0) ? $clog2(num_req) : 1;
  endfunction

  // Round-robin pointer plus burst-lock ownership.
  typedef struct packed {
    logic [MaxIdWidth-1:0] ptr;
    logic                  lock_act;
    logic [MaxIdWidth-1:0] lock_id;
  } rr_state_t;

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin pick: first valid at or above ptr (with wrap),
// or the lock owner unconditionally while a lock is active.
module rr_arb_pick #(
  parameter int unsigned NumReq  = 2,
  parameter int unsigned IdWidth = 1
) (
  input  logic [NumReq-1:0]  req_i,
  input  logic [IdWidth-1:0] ptr_i,
  input  logic               lock_act_i,
  input  logic [IdWidth-1:0] lock_id_i,
  output logic [NumReq-1:0]  grant_o,
  output logic [IdWidth-1:0] id_o
);

  localparam int unsigned SumWidth = IdWidth + 1;

  logic [NumReq-1:0]   rot;
  logic [IdWidth-1:0]  off;
  logic [SumWidth-1:0] sum;

  // Rotate requests so ptr sits at bit 0, take the lowest set bit, un-rotate.
  always_comb begin
    rot     = NumReq'({req_i, req_i} >> ptr_i);
    off     = '0;
    sum     = '0;
    id_o    = '0;
    grant_o = '0;
    if (lock_act_i) begin
      id_o    = lock_id_i;
      grant_o = NumReq'(1) << lock_id_i;
    end else if (|req_i) begin
      for (int i = NumReq - 1; i >= 0; i--) begin
        if (rot[i]) off = IdWidth'(i);
      end
      sum     = {1'b0, ptr_i} + {1'b0, off};
      id_o    = IdWidth'((sum >= SumWidth'(NumReq)) ? sum - SumWidth'(NumReq) : sum);
      grant_o = NumReq'(1) << id_o;
    end
  end

endmodule

// File: rtl/im_addr_arbiter.sv
// Round-robin arbiter sharing one item-memory read-address port between
// several address generators, with burst lock and a registered output stage.
module im_addr_arbiter
  import im_arb_pkg::*;
#(
  parameter int unsigned NumReq      = 2,
  parameter int unsigned NumTotIm    = 1024,
  parameter int unsigned ImAddrWidth = $clog2(NumTotIm),
  parameter int unsigned IdWidth     = id_width(NumReq)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic                          clr_i,
  input  logic [NumReq*ImAddrWidth-1:0] req_addr_i,
  input  logic [NumReq-1:0]             req_valid_i,
  input  logic [NumReq-1:0]             req_lock_i,
  output logic [NumReq-1:0]             req_ready_o,
  output logic [NumReq-1:0]             grant_o,
  output logic [ImAddrWidth-1:0]        im_addr_o,
  output logic [IdWidth-1:0]            im_id_o,
  output logic                          im_valid_o,
  input  logic                          im_ready_i
);

  rr_state_t st_q, st_d;

  logic [IdWidth-1:0]            ptr_q, lock_id_q, pick_ptr, pick_id;
  logic [NumReq-1:0]             pick_grant;
  logic                          lock_hold, lock_eff, lock_release;
  logic                          stage_free, accept, win_lock, flush;
  logic [NumReq*ImAddrWidth-1:0] addr_sh;
  logic [ImAddrWidth-1:0]        win_addr;
  logic                          unused_state_bits;

  function automatic logic [IdWidth-1:0] wrap_inc(input logic [IdWidth-1:0] x);
    if (32'(x) == NumReq - 1) return '0;
    return x + IdWidth'(1);
  endfunction

  assign ptr_q             = IdWidth'(st_q.ptr);
  assign lock_id_q         = IdWidth'(st_q.lock_id);
  assign unused_state_bits = ^{st_q.ptr, st_q.lock_id};

  // Owner dropping its lock releases immediately and scanning resumes after it.
  assign lock_hold    = |(req_lock_i & (NumReq'(1) << lock_id_q));
  assign lock_eff     = st_q.lock_act & lock_hold;
  assign lock_release = st_q.lock_act & ~lock_hold;
  assign pick_ptr     = lock_release ? wrap_inc(lock_id_q) : ptr_q;

  rr_arb_pick #(
    .NumReq (NumReq),
    .IdWidth(IdWidth)
  ) u_pick (
    .req_i     (req_valid_i),
    .ptr_i     (pick_ptr),
    .lock_act_i(lock_eff),
    .lock_id_i (lock_id_q),
    .grant_o   (pick_grant),
    .id_o      (pick_id)
  );

  assign flush       = ~en_i | clr_i;
  assign stage_free  = ~im_valid_o | im_ready_i;
  assign grant_o     = en_i ? pick_grant : '0;
  assign req_ready_o = (~flush & stage_free) ? grant_o : '0;
  assign accept      = |(req_valid_i & req_ready_o);
  assign win_lock    = |(req_lock_i & pick_grant);
  assign addr_sh     = req_addr_i >> (32'(pick_id) * ImAddrWidth);
  assign win_addr    = addr_sh[ImAddrWidth-1:0];

  // Pointer/lock state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) st_q <= '0;
    else         st_q <= st_d;
  end

  // Next pointer/lock: flush resets, accept rotates or locks, release advances.
  always_comb begin
    st_d = st_q;
    if (flush) begin
      st_d = '0;
    end else if (accept) begin
      if (win_lock) begin
        st_d.ptr      = MaxIdWidth'(pick_id);
        st_d.lock_act = 1'b1;
        st_d.lock_id  = MaxIdWidth'(pick_id);
      end else begin
        st_d.ptr      = MaxIdWidth'(wrap_inc(pick_id));
        st_d.lock_act = 1'b0;
        st_d.lock_id  = '0;
      end
    end else if (lock_release) begin
      st_d.ptr      = MaxIdWidth'(pick_ptr);
      st_d.lock_act = 1'b0;
      st_d.lock_id  = '0;
    end
  end

  // Output stage: load on accept, drop on drain or flush, hold while stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      im_valid_o <= 1'b0;
      im_addr_o  <= '0;
      im_id_o    <= '0;
    end else if (flush) begin
      im_valid_o <= 1'b0;
    end else if (accept) begin
      im_valid_o <= 1'b1;
      im_addr_o  <= win_addr;
      im_id_o    <= pick_id;
    end else if (im_ready_i) begin
      im_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_im_addr_arbiter.sv
// Scoreboard bench for im_addr_arbiter with NumReq=4.
module tb_im_addr_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 10;
  localparam int unsigned IW = 2;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en_i, clr_i, im_ready_i;
  logic [N*AW-1:0] req_addr_i;
  logic [N-1:0]    req_valid_i, req_lock_i;
  logic [N-1:0]    req_ready_o, grant_o;
  logic [AW-1:0]   im_addr_o;
  logic [IW-1:0]   im_id_o;
  logic            im_valid_o;

  always #5 clk = ~clk;

  im_addr_arbiter #(
    .NumReq  (N),
    .NumTotIm(1024)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en_i),
    .clr_i      (clr_i),
    .req_addr_i (req_addr_i),
    .req_valid_i(req_valid_i),
    .req_lock_i (req_lock_i),
    .req_ready_o(req_ready_o),
    .grant_o    (grant_o),
    .im_addr_o  (im_addr_o),
    .im_id_o    (im_id_o),
    .im_valid_o (im_valid_o),
    .im_ready_i (im_ready_i)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  // Reference model: rotation pointer, lock owner (-1 = none), output occupied.
  int    m_ptr   = 0;
  int    m_lock  = -1;
  bit    m_valid = 1'b0;
  beat_t exp_q[$];

  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [IW-1:0] prev_id;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_ptr   = 0;
    m_lock  = -1;
    m_valid = 1'b0;
    exp_q.delete();
  endfunction

  // One cycle: drive inputs, predict grant/ready from the model, advance model.
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] lk,
                      input logic [N*AW-1:0] a, input logic rdy,
                      input logic en, input logic clr);
    int       scan_from, eff_lock, w, idx;
    bit       released, free, acc;
    logic [N-1:0] eg, er;
    beat_t    b;
    @(posedge clk);
    #2;
    req_valid_i = v;
    req_lock_i  = lk;
    req_addr_i  = a;
    im_ready_i  = rdy;
    en_i        = en;
    clr_i       = clr;
    #1;
    released  = (m_lock >= 0) && !lk[m_lock];
    eff_lock  = ((m_lock >= 0) && lk[m_lock]) ? m_lock : -1;
    scan_from = released ? (m_lock + 1) % N : m_ptr;
    w = -1;
    if (eff_lock >= 0) w = eff_lock;
    else begin
      for (int k = 0; k < N; k++) begin
        idx = (scan_from + k) % N;
        if (v[idx] && w < 0) w = idx;
      end
    end
    eg   = (en && w >= 0) ? (N'(1) << w) : '0;
    free = !m_valid || rdy;
    er   = (en && !clr && free) ? eg : '0;
    chk("grant", 32'(grant_o), 32'(eg));
    chk("req_ready", 32'(req_ready_o), 32'(er));
    chk("im_valid", 32'(im_valid_o), 32'(m_valid));
    acc = en && !clr && free && (w >= 0) && v[w];
    if (!en || clr) begin
      model_reset();
    end else if (acc) begin
      b.addr = a[w*AW +: AW];
      b.id   = IW'(w);
      exp_q.push_back(b);
      if (lk[w]) begin m_ptr = w; m_lock = w; end
      else begin m_ptr = (w + 1) % N; m_lock = -1; end
      m_valid = 1'b1;
    end else begin
      if (released) begin m_ptr = scan_from; m_lock = -1; end
      if (rdy) m_valid = 1'b0;
    end
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic reset_mid();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req_valid_i = '0; req_lock_i = '0; im_ready_i = 1'b0; en_i = 1'b0; clr_i = 1'b0;
    #1;
    chk("rst_im_valid", 32'(im_valid_o), 32'd0);
    chk("rst_im_addr", 32'(im_addr_o), 32'd0);
    chk("rst_im_id", 32'(im_id_o), 32'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: pop and compare on every output handshake; check stall stability.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (im_valid_o && prev_stall) begin
        chk("stall_addr", 32'(im_addr_o), 32'(prev_addr));
        chk("stall_id", 32'(im_id_o), 32'(prev_id));
      end
      if (im_valid_o && im_ready_i) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL beat_unexpected: got addr %0h id %0h expected none at %0t",
                   im_addr_o, im_id_o, $time);
        end else begin
          e = exp_q.pop_front();
          chk("beat_addr", 32'(im_addr_o), 32'(e.addr));
          chk("beat_id", 32'(im_id_o), 32'(e.id));
        end
      end
      prev_stall <= im_valid_o && !im_ready_i;
      prev_addr  <= im_addr_o;
      prev_id    <= im_id_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N*AW-1:0] ra;
    logic [N-1:0]    rl;
    logic            ren, rclr, rrdy;
    rst_n = 1'b0;
    en_i = 1'b0; clr_i = 1'b0; im_ready_i = 1'b0;
    req_valid_i = '0; req_lock_i = '0; req_addr_i = '0;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("reset_im_valid", 32'(im_valid_o), 32'd0);
    chk("reset_im_addr", 32'(im_addr_o), 32'd0);
    chk("reset_im_id", 32'(im_id_o), 32'd0);
    chk("reset_grant", 32'(grant_o), 32'd0);
    chk("reset_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();

    // Single requester back-to-back: req1 addresses 5,6,7.
    for (int k = 0; k < 3; k++)
      step(4'b0010, 4'b0000, {10'd0, 10'd0, AW'(5 + k), 10'd0}, 1'b1, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, '0, 1'b1, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, '0, 1'b0, 1'b1, 1'b1);

    // All four valid: fair rotation from pointer 0.
    for (int k = 0; k < 6; k++)
      step(4'b1111, 4'b0000, {AW'(40 + k), AW'(30 + k), AW'(20 + k), AW'(10 + k)},
           1'b1, 1'b1, 1'b0);

    // Req2 holds its lock for three beats, then releases.
    for (int k = 0; k < 3; k++)
      step(4'b1111, 4'b0100, {10'd73, AW'(60 + k), 10'd51, 10'd50}, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++)
      step(4'b1111, 4'b0000, {10'd74, 10'd64, 10'd52, 10'd53}, 1'b1, 1'b1, 1'b0);

    // Stall with address 9 held for four cycles, then resume.
    step(4'b0000, 4'b0000, '0, 1'b1, 1'b1, 1'b0);
    step(4'b0001, 4'b0000, {10'd0, 10'd0, 10'd0, 10'd9}, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++)
      step(4'b0001, 4'b0000, {10'd0, 10'd0, 10'd0, 10'd9}, 1'b0, 1'b1, 1'b0);
    step(4'b0001, 4'b0000, {10'd0, 10'd0, 10'd0, 10'd9}, 1'b1, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, '0, 1'b1, 1'b1, 1'b0);

    // Clear with a beat pending and pointer at 2; next grant scans from 0.
    step(4'b0010, 4'b0000, {10'd0, 10'd0, 10'd77, 10'd0}, 1'b1, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, '0, 1'b0, 1'b1, 1'b1);
    step(4'b1111, 4'b0000, {10'd83, 10'd82, 10'd81, 10'd80}, 1'b1, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, '0, 1'b1, 1'b1, 1'b0);

    // Randomized traffic with occasional locks, stalls, clears and disables.
    for (int k = 0; k < 400; k++) begin
      ra   = (N * AW)'({$urandom(), $urandom()});
      for (int r = 0; r < N; r++) rl[r] = ($urandom_range(0, 3) == 0);
      ren  = ($urandom_range(0, 30) != 0);
      rclr = ($urandom_range(0, 30) == 0);
      rrdy = (ren && !rclr) ? ($urandom_range(0, 3) != 0) : 1'b0;
      step(N'($urandom()), rl, ra, rrdy, ren, rclr);
    end

    // Reset mid-burst; rotation must restart from requester 0.
    step(4'b0000, 4'b0000, '0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++)
      step(4'b1111, 4'b0000, {10'd4, 10'd3, 10'd2, 10'd1}, 1'b1, 1'b1, 1'b0);
    reset_mid();
    for (int k = 0; k < 5; k++)
      step(4'b1111, 4'b0000, {AW'(200 + k), AW'(150 + k), AW'(100 + k), AW'(90 + k)},
           1'b1, 1'b1, 1'b0);

    // Drain and confirm every predicted beat came out.
    for (int k = 0; k < 4; k++)
      step(4'b0000, 4'b0000, '0, 1'b1, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
